// File: rtl/sched_host_port.sv
// Host-side command agent for the EDF scheduler: register writes in, scheduler command pulses out, IRQ back.
// Build option: define SCHED_HOST_WAKE_FIFO_EN for a WAKE_DEPTH-entry wakeup FIFO; otherwise a single pending slot.
module sched_host_port #(
  parameter int MAX_TASKS  = 32,
  parameter int TIME_BITS  = 32,
  parameter int WAKE_DEPTH = 4,
  localparam int ID_W      = $clog2(MAX_TASKS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [3:0]             wr_addr,
  input  logic [31:0]            wr_data,
  output logic                   task_valid,
  output logic [ID_W-1:0]        task_id,
  output logic                   task_type,
  output logic                   task_crit,
  output logic [TIME_BITS-1:0]   task_period,
  output logic [TIME_BITS-1:0]   task_vdl,
  output logic [TIME_BITS-1:0]   task_ex_high,
  output logic [TIME_BITS-1:0]   task_ex_low,
  output logic                   wakeup_valid,
  output logic [ID_W-1:0]        wakeup_id,
  output logic                   completion_valid,
  output logic                   completion_succesful,
  output logic [4*ID_W-1:0]      transition_nums,
  output logic                   sched_en,
  input  logic                   sched_interrupt,
  input  logic [ID_W-1:0]        sched_running_task,
  input  logic                   sched_running_valid,
  output logic                   irq,
  output logic [ID_W-1:0]        irq_task,
  output logic [7:0]             irq_overrun
);

  localparam logic [3:0] A_PERIOD = 4'd0;
  localparam logic [3:0] A_VDL    = 4'd1;
  localparam logic [3:0] A_EXHI   = 4'd2;
  localparam logic [3:0] A_EXLO   = 4'd3;
  localparam logic [3:0] A_COMMIT = 4'd4;
  localparam logic [3:0] A_WAKE   = 4'd5;
  localparam logic [3:0] A_DONE   = 4'd6;
  localparam logic [3:0] A_CTRL   = 4'd7;
  localparam logic [3:0] A_ACK    = 4'd8;

  logic            commit_pend;
  logic            done_pend;
  logic            done_success;
  logic            arm;
  logic            wr_fire;
  logic            wq_full;
  logic            wq_nonempty;
  logic            wq_push;
  logic            wq_pop;
  logic [ID_W-1:0] wq_head;

  // Backpressure is decided from registered state only, so a full queue refuses a push even if it pops this cycle.
  always_comb begin
    wr_ready = 1'b1;
    case (wr_addr)
      A_PERIOD, A_VDL, A_EXHI, A_EXLO, A_COMMIT: wr_ready = ~commit_pend;
      A_WAKE:  wr_ready = ~wq_full;
      A_DONE:  wr_ready = ~done_pend;
      default: wr_ready = 1'b1;
    endcase
  end

  assign wr_fire  = wr_valid & wr_ready;
  assign wq_push  = wr_fire & (wr_addr == A_WAKE);
  assign wq_pop   = wakeup_valid;

  assign task_valid           = commit_pend & sched_en;
  // A wakeup for the task being loaded this cycle waits one cycle so the load lands first.
  assign wakeup_valid         = wq_nonempty & sched_en & ~(task_valid & (wq_head == task_id));
  assign wakeup_id            = wq_head;
  assign completion_valid     = done_pend & sched_en & sched_running_valid;
  assign completion_succesful = done_success;

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pend     <= 1'b0;
      done_pend       <= 1'b0;
      done_success    <= 1'b0;
      task_id         <= '0;
      task_type       <= 1'b0;
      task_crit       <= 1'b0;
      task_period     <= '0;
      task_vdl        <= '0;
      task_ex_high    <= '0;
      task_ex_low     <= '0;
      sched_en        <= 1'b0;
      transition_nums <= '0;
    end else begin
      if (task_valid) commit_pend <= 1'b0;
      // Completion with no running task is stale and dropped silently.
      if (done_pend && sched_en) done_pend <= 1'b0;
      if (wr_fire) begin
        case (wr_addr)
          A_PERIOD: task_period  <= TIME_BITS'(wr_data);
          A_VDL:    task_vdl     <= TIME_BITS'(wr_data);
          A_EXHI:   task_ex_high <= TIME_BITS'(wr_data);
          A_EXLO:   task_ex_low  <= TIME_BITS'(wr_data);
          A_COMMIT: begin
            task_id     <= wr_data[ID_W-1:0];
            task_type   <= wr_data[5];
            task_crit   <= wr_data[6];
            commit_pend <= 1'b1;
          end
          A_DONE: begin
            done_success <= wr_data[0];
            done_pend    <= 1'b1;
          end
          A_CTRL: begin
            sched_en <= wr_data[0];
            for (int k = 0; k < 4; k++)
              transition_nums[k*ID_W +: ID_W] <= wr_data[2+5*k +: ID_W];
          end
          default: ;
        endcase
      end
    end
  end

  // Capture wins over a same-edge acknowledge so a fresh switch is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm         <= 1'b0;
      irq         <= 1'b0;
      irq_task    <= '0;
      irq_overrun <= '0;
    end else begin
      arm <= sched_interrupt;
      if (arm) begin
        irq      <= 1'b1;
        irq_task <= sched_running_task;
        if (irq && irq_overrun != 8'hFF) irq_overrun <= irq_overrun + 8'd1;
      end else if (wr_fire && wr_addr == A_ACK) begin
        irq <= 1'b0;
      end
    end
  end

`ifdef SCHED_HOST_WAKE_FIFO_EN
  localparam int PTR_W = $clog2(WAKE_DEPTH);

  logic [ID_W-1:0]  wq_mem [WAKE_DEPTH];
  logic [PTR_W-1:0] wq_rd;
  logic [PTR_W-1:0] wq_wr;
  logic [PTR_W:0]   wq_cnt;

  assign wq_full     = (wq_cnt == (PTR_W+1)'(WAKE_DEPTH));
  assign wq_nonempty = (wq_cnt != '0);
  assign wq_head     = wq_mem[wq_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      wq_rd  <= '0;
      wq_wr  <= '0;
      wq_cnt <= '0;
    end else begin
      if (wq_push) begin
        wq_mem[wq_wr] <= wr_data[ID_W-1:0];
        wq_wr         <= wq_wr + PTR_W'(1);
      end
      if (wq_pop) wq_rd <= wq_rd + PTR_W'(1);
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt <= wq_cnt + (PTR_W+1)'(1);
        2'b01:   wq_cnt <= wq_cnt - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end
`else
  logic            wq_occ;
  logic [ID_W-1:0] wq_id;

  assign wq_full     = wq_occ;
  assign wq_nonempty = wq_occ;
  assign wq_head     = wq_id;

  // Push is only accepted when empty and pop only happens when occupied, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wq_occ <= 1'b0;
      wq_id  <= '0;
    end else if (wq_push) begin
      wq_occ <= 1'b1;
      wq_id  <= wr_data[ID_W-1:0];
    end else if (wq_pop) begin
      wq_occ <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sched_host_port.sv
// Directed bench for sched_host_port; queue depth follows SCHED_HOST_WAKE_FIFO_EN.
module tb_sched_host_port;
  localparam int ID_W = 5;
`ifdef SCHED_HOST_WAKE_FIFO_EN
  localparam int WDEPTH = 4;
`else
  localparam int WDEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [3:0]        wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic              task_valid;
  logic [ID_W-1:0]   task_id;
  logic              task_type;
  logic              task_crit;
  logic [31:0]       task_period, task_vdl, task_ex_high, task_ex_low;
  logic              wakeup_valid;
  logic [ID_W-1:0]   wakeup_id;
  logic              completion_valid;
  logic              completion_succesful;
  logic [4*ID_W-1:0] transition_nums;
  logic              sched_en;
  logic              sched_interrupt = 1'b0;
  logic [ID_W-1:0]   sched_running_task = '0;
  logic              sched_running_valid = 1'b0;
  logic              irq;
  logic [ID_W-1:0]   irq_task;
  logic [7:0]        irq_overrun;

  int errors = 0;
  int checks = 0;

  sched_host_port dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .task_valid(task_valid), .task_id(task_id), .task_type(task_type), .task_crit(task_crit),
    .task_period(task_period), .task_vdl(task_vdl), .task_ex_high(task_ex_high), .task_ex_low(task_ex_low),
    .wakeup_valid(wakeup_valid), .wakeup_id(wakeup_id),
    .completion_valid(completion_valid), .completion_succesful(completion_succesful),
    .transition_nums(transition_nums), .sched_en(sched_en),
    .sched_interrupt(sched_interrupt), .sched_running_task(sched_running_task),
    .sched_running_valid(sched_running_valid),
    .irq(irq), .irq_task(irq_task), .irq_overrun(irq_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    while (!wr_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("wr_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_sched_en", sched_en, 0);
    chk("rst_task_valid", task_valid, 0);
    chk("rst_wakeup_valid", wakeup_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // Task load
    wr(4'd7, 32'(1 | (3 << 2) | (7 << 7) | (12 << 12) | (20 << 17)));
    chk("ctrl_en", sched_en, 1);
    chk("ctrl_trans", transition_nums, {5'd20, 5'd12, 5'd7, 5'd3});
    wr(4'd0, 100);
    wr(4'd1, 60);
    wr(4'd2, 20);
    wr(4'd3, 10);
    wr(4'd4, 32'(3 | (0 << 5) | (1 << 6)));
    chk("t1_valid", task_valid, 1);
    chk("t1_id", task_id, 3);
    chk("t1_type", task_type, 0);
    chk("t1_crit", task_crit, 1);
    chk("t1_period", task_period, 100);
    chk("t1_vdl", task_vdl, 60);
    chk("t1_exhi", task_ex_high, 20);
    chk("t1_exlo", task_ex_low, 10);
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 200;
    #1;
    chk("t1_stall", wr_ready, 0);
    @(negedge clk); #1;
    chk("t1_pulse_once", task_valid, 0);
    chk("t1_unstall", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("t1_period2", task_period, 200);

    // Wakeup queue fill and drain
    wr(4'd7, 0);
    for (int i = 1; i <= WDEPTH; i++) wr(4'd5, 32'(i));
    chk("t2_hold", wakeup_valid, 0);
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 9;
    #1;
    chk("t2_full", wr_ready, 0);
    wr_valid = 1'b0;
    wr(4'd7, 1);
    for (int i = 1; i <= WDEPTH; i++) begin
      chk("t2_wv", wakeup_valid, 1);
      chk("t2_wid", wakeup_id, 64'(i));
      @(negedge clk); #1;
    end
    chk("t2_empty", wakeup_valid, 0);

    // Same-ID conflict
    wr(4'd7, 0);
    wr(4'd5, 5);
    wr(4'd4, 32'(5 | (1 << 5)));
    wr(4'd7, 1);
    chk("t3_task", task_valid, 1);
    chk("t3_tid", task_id, 5);
    chk("t3_ttype", task_type, 1);
    chk("t3_defer", wakeup_valid, 0);
    @(negedge clk); #1;
    chk("t3_task_off", task_valid, 0);
    chk("t3_wv", wakeup_valid, 1);
    chk("t3_wid", wakeup_id, 5);
    @(negedge clk); #1;
    chk("t3_wv_off", wakeup_valid, 0);

    // All three pulses together
    wr(4'd7, 0);
    wr(4'd5, 9);
    wr(4'd4, 4);
    wr(4'd6, 1);
    sched_running_valid = 1'b1;
    wr(4'd7, 1);
    chk("tri_task", task_valid, 1);
    chk("tri_wake", wakeup_valid, 1);
    chk("tri_wid", wakeup_id, 9);
    chk("tri_comp", completion_valid, 1);
    @(negedge clk); #1;

    // Completion
    wr(4'd6, 1);
    chk("t4_cv", completion_valid, 1);
    chk("t4_cs", completion_succesful, 1);
    @(negedge clk); #1;
    chk("t4_cv_off", completion_valid, 0);
    wr(4'd6, 0);
    chk("t4_cv_blk", completion_valid, 1);
    chk("t4_cs_blk", completion_succesful, 0);
    @(negedge clk); #1;
    sched_running_valid = 1'b0;
    wr(4'd6, 1);
    chk("t4_stale", completion_valid, 0);
    @(negedge clk);
    sched_running_valid = 1'b1;
    #1;
    chk("t4_dropped", completion_valid, 0);

    // Interrupt capture
    sched_interrupt = 1'b1; sched_running_task = 0;
    @(negedge clk);
    sched_interrupt = 1'b0; sched_running_task = 7;
    #1;
    chk("t5_lat", irq, 0);
    @(negedge clk); #1;
    chk("t5_irq", irq, 1);
    chk("t5_task", irq_task, 7);
    chk("t5_ovr0", irq_overrun, 0);
    sched_interrupt = 1'b1;
    @(negedge clk);
    sched_interrupt = 1'b0; sched_running_task = 9;
    @(negedge clk); #1;
    chk("t5_task2", irq_task, 9);
    chk("t5_ovr1", irq_overrun, 1);
    sched_interrupt = 1'b1;
    @(negedge clk);
    sched_interrupt = 1'b0; sched_running_task = 11;
    wr_valid = 1'b1; wr_addr = 4'd8; wr_data = 0;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("t5_ack_race", irq, 1);
    chk("t5_task3", irq_task, 11);
    chk("t5_ovr2", irq_overrun, 2);
    wr(4'd8, 0);
    chk("t5_ack", irq, 0);

    // Reset mid-operation
    wr(4'd7, 0);
    nw = (WDEPTH < 3) ? WDEPTH : 3;
    for (int i = 0; i < nw; i++) wr(4'd5, 32'(i + 2));
    wr(4'd4, 1);
    sched_interrupt = 1'b1; sched_running_task = 13;
    @(negedge clk);
    sched_interrupt = 1'b0;
    @(negedge clk); #1;
    chk("t6_pre_irq", irq, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_irq", irq, 0);
    chk("t6_irq_task", irq_task, 0);
    chk("t6_ovr", irq_overrun, 0);
    chk("t6_en", sched_en, 0);
    chk("t6_trans", transition_nums, 0);
    chk("t6_period", task_period, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_cv", completion_valid, 0);
    wr(4'd7, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_wake", wakeup_valid, 0);
      chk("t6_no_task", task_valid, 0);
      @(negedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sched_host_port.md
# sched_host_port

- Processor-side command agent for the mixed-criticality EDF scheduler.
- Turns a simple single-beat register write port into the scheduler's inputs, one cycle at a time:
  - task-table load;
  - wakeup requests, buffered;
  - job completion;
  - criticality transition thresholds;
  - scheduler enable.
- In the reverse direction, converts the scheduler's context-switch pulse into a level interrupt with a captured task ID, held until software acknowledges it.

## Interface
Parameters:
- MAX_TASKS, 32, number of task slots; ID_W = $clog2(MAX_TASKS).
- TIME_BITS, 32, width of time fields.
- WAKE_DEPTH, 4, wakeup FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready at a rising edge.
- wr_addr  in  4  register address.
- wr_data  in  32  write data.
- task_valid  out  1  task-table load pulse.
- task_id  out  ID_W  task slot.
- task_type  out  1  0 periodic, 1 sporadic.
- task_crit  out  1  0 low, 1 high.
- task_period / task_vdl / task_ex_high / task_ex_low  out  TIME_BITS each  staged timing values.
- wakeup_valid  out  1  wakeup pulse.
- wakeup_id  out  ID_W  task to wake.
- completion_valid  out  1  completion pulse.
- completion_succesful  out  1  1 = job done, 0 = job blocked.
- transition_nums  out  4×ID_W  criticality thresholds.
- sched_en  out  1  scheduler enable.
- sched_interrupt  in  1  context-switch pulse from the scheduler.
- sched_running_task  in  ID_W  current running task.
- sched_running_valid  in  1  running task is valid.
- irq  out  1  level interrupt to the CPU.
- irq_task  out  ID_W  running task captured at the switch.
- irq_overrun  out  8  saturating count of switches taken while irq was already set.

## Operation
Register map (wr_addr):
- 0 PERIOD, 1 VDL, 2 EXHI, 3 EXLO: staging registers that feed the task_* timing outputs directly.
- 4 COMMIT:
  - fields: [ID_W-1:0] id, [5] type, [6] crit;
  - sets commit_pend.
- 5 WAKE: [ID_W-1:0] id is pushed into the wakeup FIFO.
- 6 DONE: [0] success; sets done_pend.
- 7 CTRL:
  - [0] sched_en;
  - [2+5k+:5] transition_nums[k], k = 0..3;
  - all fields are written together.
- 8 IRQ_ACK: clears irq (data ignored).
- 9–15: the write is accepted and has no effect.

wr_ready is 0 when any of the following holds:
- addr 0–4 while commit_pend is set (staging must stay stable until issued);
- addr 5 while the FIFO is full;
- addr 6 while done_pend is set.

Otherwise wr_ready is 1.

Issue logic is combinational from registered state and is gated by sched_en:
- task_valid = commit_pend & sched_en; commit_pend clears on the same edge.
- wakeup_valid = fifo_nonempty & sched_en & ~(task_valid & head_id == task_id). On a same-ID conflict the wakeup is deferred one cycle. When it issues, the FIFO pops.
- completion_valid = done_pend & sched_en & sched_running_valid; done_pend clears.
  - If done_pend & sched_en & ~sched_running_valid, done_pend clears with no pulse (stale completion dropped).
- task, wakeup and completion may all pulse in the same cycle.
- With sched_en = 0, all pending state holds indefinitely.

Interrupt path:
- When sched_interrupt is seen in cycle N, arm is set.
- In cycle N+1: irq_task <= sched_running_task; irq <= 1.
  - If irq was already 1, irq_overrun increments, saturating at 255.
- IRQ_ACK write and a capture on the same edge: the capture wins and irq stays 1.

## Timing
- A write accepted at the edge ending cycle N produces its pulse in cycle N+1 at the earliest (FIFO or pending slot in between).
- Wakeups issue at most one per cycle, in FIFO order.
- Interrupt latency: irq is visible 2 cycles after the sched_interrupt cycle.
- Simultaneous FIFO push and pop when the FIFO is full: the push is refused (wr_ready = 0 is computed before the pop).
- Reset values:
  - irq = 0, irq_task = 0, irq_overrun = 0;
  - sched_en = 0, transition_nums = 0;
  - all *_valid outputs = 0;
  - FIFO empty, pending flags = 0, staging = 0, wr_ready = 1.
- Reset mid-operation discards all queued wakeups, pending commands and arm.

## Configuration
- SCHED_HOST_WAKE_FIFO_EN defined: the wakeup queue is a WAKE_DEPTH-entry FIFO.
- Undefined: the wakeup queue is a single pending register. WAKE writes stall while it is occupied; all other behaviour is identical.

## Test plan
1. **Task load.** Write PERIOD=100, VDL=60, EXHI=20, EXLO=10, then COMMIT id=3, type=0, crit=1, with sched_en=1 -> task_valid pulses 1 cycle later with exactly those values.
   - A PERIOD write issued during the pending cycle stalls until the commit issues.
2. **Wakeup FIFO.** With sched_en=0, push WAKE 1,2,3,4 -> a fifth write sees wr_ready=0. Then set sched_en=1 -> wakeup_id 1,2,3,4 on consecutive cycles.
3. **Same-ID conflict.** COMMIT id=5 and WAKE 5 pending together -> task_valid in cycle k, wakeup_valid for id 5 in cycle k+1.
4. **Completion.** DONE success=1 with sched_running_valid=1 -> completion_valid=1, completion_succesful=1 for one cycle. The same with sched_running_valid=0 -> no pulse and done_pend cleared.
5. **Interrupt capture.** Pulse sched_interrupt with sched_running_task becoming 7 the next cycle -> irq=1, irq_task=7 two cycles later.
   - A second pulse before ack -> irq_overrun=1 and irq_task updated to the new task.
   - IRQ_ACK on the same edge as a capture -> irq stays 1.
6. **Reset.** Assert rst with 3 wakeups queued and irq set -> all outputs return to their reset values the next cycle and no wakeup issues afterwards.
